// File: rtl/chess_move_pkg.sv
// Shared move format and collector state encodings for the board-level move path.
package chess_move_pkg;

    localparam int MOVE_W     = 19;
    localparam int SLOTS      = 8;
    localparam int COL_WORD_W = 152;

    localparam int INVALID = 18;
    localparam int PROMOTE = 17;
    localparam int PAWN    = 16;
    localparam int PAWN2   = 15;
    localparam int EP      = 14;
    localparam int CASTLE  = 13;
    localparam int CAPTURE = 12;

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        WAITQ = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/move_collector_rr_arbiter.sv
// Round-robin priority select: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NCOL = 8,
    localparam int PW  = $clog2(NCOL)
) (
    input  logic [NCOL-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NCOL-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            found
);

    int c;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        c         = 0;
        for (int i = 0; i < NCOL; i++) begin
            c = (int'(ptr) + i) % NCOL;
            if (!found && req[c]) begin
                found     = 1'b1;
                grant[c]  = 1'b1;
                grant_idx = PW'(c);
            end
        end
    end

endmodule

// File: rtl/move_collector.sv
// Drains column move FIFO words, drops invalid slots and streams valid moves
// over a registered valid/ready interface while counting them.
//   state | meaning
//   SCAN  | pick next non-empty column, or count quiet cycles toward DONE
//   WAITQ | FIFO read latency; word is latched at the end of this cycle
//   EMIT  | present one slot per cycle, holding valid moves until accepted
//   DONE  | all columns finished and drained; sticky until reset
module move_collector
    import chess_move_pkg::*;
#(
    parameter int NCOL   = 8,
    parameter int SLOTS  = 8,
    parameter int MOVE_W = 19,
    parameter int CNT_W  = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NCOL-1:0]                col_done,
    input  logic [NCOL-1:0]                col_empty,
    input  logic [NCOL*SLOTS*MOVE_W-1:0]   col_data,
    output logic [NCOL-1:0]                col_rden,
    output logic [MOVE_W-1:0]              move_out,
    output logic                           move_valid,
    input  logic                           move_ready,
    output logic [CNT_W-1:0]               move_count,
    output logic                           overflow,
    output logic                           done
);

    localparam int WORD_W = SLOTS * MOVE_W;
    localparam int PW     = $clog2(NCOL);
    localparam int SW     = $clog2(SLOTS);

    state_e              state_q, state_d;
    logic [PW-1:0]       col_ptr_q, col_ptr_d;
    logic [PW-1:0]       col_sel_q, col_sel_d;
    logic [1:0]          quiet_q, quiet_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [SW-1:0]       slot_q, slot_d;
    logic [MOVE_W-1:0]   move_out_q, move_out_d;
    logic                move_valid_q, move_valid_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                overflow_q, overflow_d;

    logic [NCOL-1:0]     grant;
    logic [PW-1:0]       grant_idx;
    logic                found;
    logic [WORD_W-1:0]   sel_word;
    logic [MOVE_W-1:0]   first_slot;
    logic [MOVE_W-1:0]   nxt_slot;
    logic [SW-1:0]       slot_nx;

    rr_arbiter #(.NCOL(NCOL)) u_arb (
        .req       (~col_empty),
        .ptr       (col_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .found     (found)
    );

    assign sel_word   = col_data[int'(col_sel_q)*WORD_W +: WORD_W];
    assign first_slot = sel_word[MOVE_W-1:0];
    assign slot_nx    = slot_q + 1'b1;
    assign nxt_slot   = word_q[int'(slot_nx)*MOVE_W +: MOVE_W];

    always_comb begin
        state_d      = state_q;
        col_ptr_d    = col_ptr_q;
        col_sel_d    = col_sel_q;
        quiet_d      = '0;
        word_d       = word_q;
        slot_d       = slot_q;
        move_out_d   = move_out_q;
        move_valid_d = move_valid_q;
        col_rden     = '0;
        unique case (state_q)
            SCAN: begin
                if (found) begin
                    col_rden  = reset ? '0 : grant;
                    col_sel_d = grant_idx;
                    col_ptr_d = (grant_idx == PW'(NCOL-1)) ? '0 : grant_idx + 1'b1;
                    state_d   = WAITQ;
                end else if (&col_done && &col_empty) begin
                    // Two quiet cycles let a column's registered last write land.
                    quiet_d = quiet_q + 2'd1;
                    if (quiet_q == 2'd1) state_d = DONE;
                end
            end
            WAITQ: begin
                word_d       = sel_word;
                slot_d       = '0;
                move_valid_d = !first_slot[INVALID];
                if (!first_slot[INVALID]) move_out_d = first_slot;
                state_d      = EMIT;
            end
            EMIT: begin
                if (!move_valid_q || move_ready) begin
                    if (slot_q == SW'(SLOTS-1)) begin
                        move_valid_d = 1'b0;
                        state_d      = SCAN;
                    end else begin
                        slot_d       = slot_nx;
                        move_valid_d = !nxt_slot[INVALID];
                        if (!nxt_slot[INVALID]) move_out_d = nxt_slot;
                    end
                end
            end
            DONE: ;
            default: state_d = SCAN;
        endcase
    end

    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        if (move_valid_q && move_ready) begin
            if (count_q == '1) overflow_d = 1'b1;
            else               count_d    = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SCAN;
            col_ptr_q    <= '0;
            col_sel_q    <= '0;
            quiet_q      <= '0;
            word_q       <= '0;
            slot_q       <= '0;
            move_out_q   <= '0;
            move_valid_q <= 1'b0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_ptr_q    <= col_ptr_d;
            col_sel_q    <= col_sel_d;
            quiet_q      <= quiet_d;
            word_q       <= word_d;
            slot_q       <= slot_d;
            move_out_q   <= move_out_d;
            move_valid_q <= move_valid_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign move_out   = move_out_q;
    assign move_valid = move_valid_q;
    assign move_count = count_q;
    assign overflow   = overflow_q;
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_move_collector.sv
// Directed bench for move_collector with a one-word-per-column FIFO model.
module tb_move_collector;

    localparam int NCOL   = 8;
    localparam int SLOTS  = 8;
    localparam int MOVE_W = 19;
    localparam int CNT_W  = 4;
    localparam int WORD_W = SLOTS * MOVE_W;
    localparam logic [MOVE_W-1:0] INV = 19'h40000;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NCOL-1:0]            col_done;
    logic [NCOL-1:0]            col_empty;
    logic [NCOL*WORD_W-1:0]     col_data;
    logic [NCOL-1:0]            col_rden;
    logic [MOVE_W-1:0]          move_out;
    logic                       move_valid;
    logic                       move_ready;
    logic [CNT_W-1:0]           move_count;
    logic                       overflow;
    logic                       done;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    move_collector #(.NCOL(NCOL), .SLOTS(SLOTS), .MOVE_W(MOVE_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .col_done   (col_done),
        .col_empty  (col_empty),
        .col_data   (col_data),
        .col_rden   (col_rden),
        .move_out   (move_out),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .move_count (move_count),
        .overflow   (overflow),
        .done       (done)
    );

    logic [WORD_W-1:0] pend_word [NCOL];
    int push_cnt [NCOL] = '{default: 0};
    int pop_cnt  [NCOL] = '{default: 0};

    always_comb begin
        col_empty = '0;
        for (int i = 0; i < NCOL; i++) col_empty[i] = (push_cnt[i] == pop_cnt[i]);
    end

    always @(posedge clk) begin
        for (int i = 0; i < NCOL; i++) begin
            if (col_rden[i]) begin
                col_data[i*WORD_W +: WORD_W] <= pend_word[i];
                pop_cnt[i] <= pop_cnt[i] + 1;
            end
        end
    end

    logic [MOVE_W-1:0] acc_log [$];
    int                rd_log  [$];

    always @(negedge clk) begin
        if (!reset && move_valid && move_ready) acc_log.push_back(move_out);
        for (int i = 0; i < NCOL; i++) if (col_rden[i]) rd_log.push_back(i);
        n_assert++;
        assert (((col_rden & col_empty) == '0) && $onehot0(col_rden))
        else begin
            n_fail++;
            $error("FAIL rden_legal observed rden=%b empty=%b required one-hot read of non-empty column",
                   col_rden, col_empty);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int c, input logic [WORD_W-1:0] w);
        pend_word[c] = w;
        push_cnt[c]  = push_cnt[c] + 1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    function automatic logic [WORD_W-1:0] mkword(input logic [MOVE_W-1:0] s0, s1, s2, s3,
                                                 s4, s5, s6, s7);
        return {s7, s6, s5, s4, s3, s2, s1, s0};
    endfunction

    function automatic logic [WORD_W-1:0] seqword(input logic [MOVE_W-1:0] b, input int nvalid);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int k = 0; k < SLOTS; k++)
            w[k*MOVE_W +: MOVE_W] = (k < nvalid) ? b + MOVE_W'(k) : INV;
        return w;
    endfunction

    int base, rbase;

    initial begin
        reset      = 1'b1;
        col_done   = '0;
        move_ready = 1'b0;
        step(2);
        @(negedge clk);
        check("rst_rden", col_rden, 0);
        check("rst_move_out", move_out, 0);
        check("rst_move_valid", move_valid, 0);
        check("rst_count", move_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_done", done, 0);
        step(1);
        reset = 1'b0;

        // Single column, slots 0 and 2 valid
        base  = acc_log.size();
        rbase = rd_log.size();
        move_ready = 1'b1;
        push(3, mkword(19'h00C1A, INV, 19'h00D2B, INV, INV, INV, INV, INV));
        step(15);
        check("s1_nmoves", acc_log.size() - base, 2);
        check("s1_move0", acc_log[base], 32'h00C1A);
        check("s1_move1", acc_log[base+1], 32'h00D2B);
        check("s1_count", move_count, 2);
        check("s1_nreads", rd_log.size() - rbase, 1);
        check("s1_read_col", rd_log[rbase], 3);
        col_done = '1;
        @(negedge clk);
        check("s1_done_q0", done, 0);
        @(negedge clk);
        check("s1_done_q1", done, 0);
        @(negedge clk);
        check("s1_done", done, 1);
        check("s1_valid_in_done", move_valid, 0);

        // Round-robin from col_ptr = 2
        col_done = '0;
        step(1);
        do_reset();
        base  = acc_log.size();
        rbase = rd_log.size();
        push(1, seqword(19'h0, 0));
        step(12);
        check("s2_ptr_pre", dut.col_ptr_q, 2);
        push(1, mkword(19'h00101, INV, INV, INV, INV, INV, INV, INV));
        push(6, mkword(19'h00606, INV, INV, INV, INV, INV, INV, INV));
        step(25);
        check("s2_nmoves", acc_log.size() - base, 2);
        check("s2_first", acc_log[base], 32'h00606);
        check("s2_second", acc_log[base+1], 32'h00101);
        check("s2_read1", rd_log[rbase+1], 6);
        check("s2_read2", rd_log[rbase+2], 1);
        check("s2_ptr_post", dut.col_ptr_q, 2);

        // Backpressure on a valid slot
        do_reset();
        move_ready = 1'b0;
        push(2, mkword(19'h01234, 19'h02345, INV, INV, INV, INV, INV, INV));
        step(2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("s3_hold_valid", move_valid, 1);
            check("s3_hold_out", move_out, 32'h01234);
            check("s3_hold_count", move_count, 0);
            step(1);
        end
        move_ready = 1'b1;
        @(negedge clk);
        check("s3_accept_out", move_out, 32'h01234);
        step(1);
        @(negedge clk);
        check("s3_next_valid", move_valid, 1);
        check("s3_next_out", move_out, 32'h02345);
        check("s3_next_count", move_count, 1);
        step(10);

        // Late write after one quiet cycle
        do_reset();
        base = acc_log.size();
        col_done = '1;
        @(negedge clk);
        check("s4_done_early", done, 0);
        step(1);
        push(0, mkword(19'h00ABC, INV, INV, INV, INV, INV, INV, INV));
        @(negedge clk);
        check("s4_rden", col_rden, 1);
        check("s4_done_at_read", done, 0);
        step(10);
        @(negedge clk);
        check("s4_done_before_quiet", done, 0);
        step(2);
        @(negedge clk);
        check("s4_done", done, 1);
        check("s4_move", acc_log[base], 32'h00ABC);
        check("s4_count", move_count, 1);
        col_done = '0;

        // Counter saturation (CNT_W = 4)
        do_reset();
        base = acc_log.size();
        push(0, seqword(19'h00100, 8));
        push(1, seqword(19'h00110, 7));
        step(25);
        check("s5_count15", move_count, 15);
        check("s5_no_overflow", overflow, 0);
        push(2, seqword(19'h00120, 2));
        step(15);
        check("s5_nmoves", acc_log.size() - base, 17);
        check("s5_count_sat", move_count, 15);
        check("s5_overflow", overflow, 1);

        // Reset during EMIT at slot 3
        do_reset();
        push(4, seqword(19'h00200, 8));
        step(5);
        @(negedge clk);
        check("s6_pre_out", move_out, 32'h00203);
        check("s6_pre_count", move_count, 3);
        reset = 1'b1;
        @(negedge clk);
        check("s6_valid", move_valid, 0);
        check("s6_out", move_out, 0);
        check("s6_count", move_count, 0);
        check("s6_done", done, 0);
        check("s6_state", dut.state_q, 0);
        check("s6_rden", col_rden, 0);
        step(1);
        reset = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/move_collector.md
Name: move_collector

Overview:
- Board-level stage directly downstream of the eight column units.
- Drains each column's 152-bit move FIFO word, which carries 8 slots of 19-bit moves.
- Unpacks the slots, discards invalid moves, and streams valid moves one per cycle over a valid/ready interface to the move-list consumer.
- Tracks the total move count and asserts done once every column is finished and drained.

Parameters:
- NCOL, 8: number of column units.
- SLOTS, 8: move slots per column FIFO word.
- MOVE_W, 19: move width. Format is [18:12] flag, [11:6] from, [5:0] to; bit 18 = invalid.
- CNT_W, 8: move counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- col_done  in  NCOL  per-column done flags; bit i = column xpos i.
- col_empty  in  NCOL  per-column FIFO empty flags.
- col_data  in  NCOL*152  column FIFO outputs; column i occupies [152*i+151:152*i].
- col_rden  out  NCOL  one-hot FIFO read enable.
- move_out  out  MOVE_W  current move.
- move_valid  out  1  move_out holds a valid move.
- move_ready  in  1  consumer accepts move_out this cycle.
- move_count  out  CNT_W  number of valid moves accepted since reset; saturating.
- overflow  out  1  sticky; a move was accepted while move_count = 2^CNT_W-1.
- done  out  1  sticky; all moves collected.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values: col_rden=0, move_out=0, move_valid=0, move_count=0, overflow=0, done=0, col_ptr=0, state=SCAN, quiet counter=0.
- Column FIFO timing: normal (non-showahead) mode. col_data is valid exactly one cycle after the cycle col_rden is high.
- Word layout: slot k = bits [19*k+18:19*k]. Slot 0 is emitted first, slot 7 last.
- States:
  - SCAN:
    - Round-robin search starts at col_ptr for the first column with col_empty=0.
    - If found at column c: drive col_rden = one-hot(c) for exactly one cycle, set col_ptr = (c+1) mod NCOL, go to WAITQ.
    - If none found and col_done=all-ones and col_empty=all-ones: increment quiet counter. When it reaches 2 (two consecutive cycles), go to DONE. Any other cycle clears the quiet counter. This covers a column's registered final write landing after its done flag.
  - WAITQ: col_rden=0. One-cycle latency wait. Next cycle, latch the selected col_data into the word register, slot index=0, go to EMIT.
  - EMIT: one slot per cycle.
    - Slot with bit 18 = 1: skipped in that cycle; move_valid stays 0.
    - Valid slot: move_out=slot and move_valid=1, held stable until move_ready=1. Then advance.
    - After slot 7 is consumed or skipped, return to SCAN.
    - A word of 8 invalid slots costs 8 cycles.
  - DONE: done=1, no reads, move_valid=0. Stays here until reset.
- Handshake: move_out and move_valid are registered. While move_valid=1 and move_ready=0, move_out must not change. move_ready while move_valid=0 is ignored.
- Counter: move_count increments on each move_valid & move_ready cycle. At 2^CNT_W-1 it holds and sets overflow.
- Only one column read is outstanding at a time. col_rden is never asserted outside SCAN.
- Simultaneous events: several non-empty columns resolve by round-robin order from col_ptr. A column that becomes non-empty after its done flag is still drained, because done requires all-empty.
- Reset mid-operation: the latched word is discarded and all outputs return to reset values next cycle. Column FIFOs are not flushed; they are reset by their own units.

Decomposition:
- Shared package chess_move_pkg holds:
  - MOVE_W, SLOTS, COL_WORD_W=152.
  - Flag bit indices: INVALID=18, PROMOTE=17, PAWN=16, PAWN2=15, EP=14, CASTLE=13, CAPTURE=12.
  - State encodings SCAN/WAITQ/EMIT/DONE.
- One natural sub-module: rr_arbiter (NCOL-wide round-robin priority select over ~col_empty with pointer input; returns one-hot grant and found flag).

Test Plan:
- Single column 3 non-empty, one word with slots 0,2 valid (0x00C1A, 0x00D2B) and the rest 0x40000, move_ready=1 → col_rden[3] pulses once. Exactly two moves are emitted in order, move_count=2. Done asserts after all col_done=0xFF, empty=0xFF for 2 cycles.
- Columns 1 and 6 non-empty with col_ptr=2 → column 6 is read before column 1. col_ptr ends at 2.
- Backpressure: move_ready=0 for 5 cycles on a valid slot → move_out is stable and move_valid=1 throughout. Next slot appears the cycle after move_ready=1.
- Late write: col_done=0xFF, empty=0xFF for 1 cycle, then col_empty[0] drops → no done. The word is drained, then done.
- Saturation with CNT_W=4: 17 valid moves → move_count=15, overflow=1.
- Reset asserted mid-EMIT at slot 3 → next cycle move_valid=0, move_count=0, state SCAN, done=0.
